// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and stall controller for a five-stage in-order pipeline.
//
// Decides each cycle which stage registers advance (en_f..en_w) and which
// pipeline registers are loaded with a bubble (flush_d, flush_e). It handles
// data-memory stalls with a timeout that halts the core, taken-branch
// redirects with a one-cycle fetch bubble, and load-use hazards.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rs1_d, rs2_d             decode-stage source registers
//   rs1_need, rs2_need       decode instruction actually reads rs1 / rs2
//   rd_e, reg_we_e, wb_ctr_e EX-stage destination, write enable, writeback select (2'b01 = load)
//   branch_taken_e           EX resolved a taken branch/jump
//   dmem_req, dmem_ack       data-memory handshake (see below)
//   en_f..en_w               stage-register enables
//   flush_d, flush_e         load a bubble into the D / E register at the edge
//   mem_err                  one-cycle pulse on entry to HALT after a memory timeout
//   halted                   controller is in HALT
//   stall_cnt                saturating count of cycles with en_d = 0
//   state_dbg                current FSM state (RUN=0, MEM_WAIT=1, REDIRECT=2, HALT=3)
//
// Memory handshake: dmem_req is held high by the MEM stage for the whole
// access; the access completes in the cycle where dmem_req and dmem_ack are
// both high. Any cycle with dmem_req=1 and dmem_ack=0 freezes the pipeline.
module pipe_ctrl #(
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           rs1_d,
    input  logic [4:0]           rs2_d,
    input  logic                 rs1_need,
    input  logic                 rs2_need,
    input  logic [4:0]           rd_e,
    input  logic                 reg_we_e,
    input  logic [1:0]           wb_ctr_e,
    input  logic                 branch_taken_e,
    input  logic                 dmem_req,
    input  logic                 dmem_ack,
    output logic                 en_f,
    output logic                 en_d,
    output logic                 en_e,
    output logic                 en_m,
    output logic                 en_w,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic                 mem_err,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [1:0]           state_dbg
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } state_t;

    state_t            state, next_state;
    logic [WAIT_W-1:0] wait_cnt, next_wait;

    logic memstall;
    logic loaduse;
    logic resolve;      // normal RUN decision applies this cycle
    logic bubble;       // REDIRECT fetch bubble proceeds this cycle

    assign memstall = dmem_req & ~dmem_ack;
    assign loaduse  = reg_we_e & (wb_ctr_e == 2'b01) & (rd_e != 5'd0) &
                      ((rs1_need & (rs1_d == rd_e)) | (rs2_need & (rs2_d == rd_e)));

    // MEM_WAIT with an ack behaves exactly like an unstalled RUN cycle.
    assign resolve = ((state == RUN) & ~memstall) | ((state == MEM_WAIT) & dmem_ack);
    assign bubble  = (state == REDIRECT) & ~memstall;

    assign state_dbg = state;

    // ---------------------------------------------------------------
    // State register, wait counter, error pulse, stall counter
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait;
            mem_err  <= (state != HALT) & (next_state == HALT);
            if (!en_d && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        next_state = state;
        next_wait  = wait_cnt;
        if (resolve) begin
            next_wait  = '0;
            next_state = branch_taken_e ? REDIRECT : RUN;
        end else if (bubble) begin
            next_wait  = '0;
            next_state = RUN;
        end else begin
            case (state)
                RUN: begin
                    // memstall in RUN: first frozen cycle already spent
                    next_state = MEM_WAIT;
                    next_wait  = WAIT_W'(1);
                end
                MEM_WAIT, REDIRECT: begin
                    if (wait_cnt >= WAIT_MAX) begin
                        next_state = HALT;
                    end else begin
                        next_wait = wait_cnt + 1'b1;
                    end
                end
                default: next_state = HALT;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Output logic
    // ---------------------------------------------------------------
    always_comb begin
        en_f    = 1'b0;
        en_d    = 1'b0;
        en_e    = 1'b0;
        en_m    = 1'b0;
        en_w    = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        halted  = 1'b0;
        if (!rst) begin
            halted = (state == HALT);
            if (resolve) begin
                en_e = 1'b1;
                en_m = 1'b1;
                en_w = 1'b1;
                if (branch_taken_e) begin
                    // redirect kills both the fetched and the decoded instruction
                    en_f    = 1'b1;
                    en_d    = 1'b1;
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (loaduse) begin
                    // hold F/D, insert a bubble into EX
                    flush_e = 1'b1;
                end else begin
                    en_f = 1'b1;
                    en_d = 1'b1;
                end
            end else if (bubble) begin
                // fetch latency after redirect: the D register gets a bubble
                en_f    = 1'b1;
                en_d    = 1'b1;
                en_e    = 1'b1;
                en_m    = 1'b1;
                en_w    = 1'b1;
                flush_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus a randomized run, all checked
// against a cycle-level reference model of the controller's rules.
module tb_pipe_ctrl;

  localparam int TIMEOUT = 16;
  localparam int W = 29;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1_d, rs2_d, rd_e;
  logic rs1_need, rs2_need, reg_we_e, branch_taken_e, dmem_req, dmem_ack;
  logic [1:0] wb_ctr_e;

  logic en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, mem_err, halted;
  logic [15:0] stall_cnt;
  logic [1:0] state_dbg;

  logic s_en_f, s_en_d, s_en_e, s_en_m, s_en_w, s_flush_d, s_flush_e, s_mem_err, s_halted;
  logic [3:0] stall_cnt_sat;
  logic [1:0] s_state_dbg;

  logic [W-1:0] obs;
  logic [W-1:0] exp_q[$];

  int checks;
  int errors;

  // reference model state
  bit m_halted, m_redirect, m_err, exp_frozen;
  int m_frozen, m_stall, m_stall_sat;
  logic [7:0] exp_ctl;

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_need(rs1_need),
    .rs2_need(rs2_need), .rd_e(rd_e), .reg_we_e(reg_we_e), .wb_ctr_e(wb_ctr_e),
    .branch_taken_e(branch_taken_e), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
    .flush_d(flush_d), .flush_e(flush_e), .mem_err(mem_err), .halted(halted),
    .stall_cnt(stall_cnt), .state_dbg(state_dbg)
  );

  pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_need(rs1_need),
    .rs2_need(rs2_need), .rd_e(rd_e), .reg_we_e(reg_we_e), .wb_ctr_e(wb_ctr_e),
    .branch_taken_e(branch_taken_e), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .en_f(s_en_f), .en_d(s_en_d), .en_e(s_en_e), .en_m(s_en_m), .en_w(s_en_w),
    .flush_d(s_flush_d), .flush_e(s_flush_e), .mem_err(s_mem_err), .halted(s_halted),
    .stall_cnt(stall_cnt_sat), .state_dbg(s_state_dbg)
  );

  assign obs = {en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, halted,
                mem_err, stall_cnt, stall_cnt_sat};

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    rs1_d = 5'd0; rs2_d = 5'd0; rs1_need = 1'b0; rs2_need = 1'b0;
    rd_e = 5'd0; reg_we_e = 1'b0; wb_ctr_e = 2'b00;
    branch_taken_e = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic model_clear();
    m_halted = 0; m_redirect = 0; m_err = 0; m_frozen = 0;
    m_stall = 0; m_stall_sat = 0; exp_frozen = 0; exp_ctl = 8'h00;
  endtask

  // Evaluate the model for the inputs now applied and queue the expected
  // observation. ctl = {en_f,en_d,en_e,en_m,en_w,flush_d,flush_e,halted}.
  task automatic settle();
    bit lu, ms, frozen;
    logic [7:0] ctl;
    #1;
    lu = reg_we_e && (wb_ctr_e == 2'b01) && (rd_e != 0) &&
         ((rs1_need && rs1_d == rd_e) || (rs2_need && rs2_d == rd_e));
    ms = dmem_req && !dmem_ack;
    frozen = 0;
    if (rst) ctl = 8'h00;
    else if (m_halted) ctl = 8'b00000_00_1;
    else begin
      // an outstanding memory wait only ends with an ack
      frozen = m_redirect ? ms : ((m_frozen > 0) ? !dmem_ack : ms);
      if (frozen) ctl = 8'h00;
      else if (m_redirect) ctl = 8'b11111_10_0;
      else if (branch_taken_e) ctl = 8'b11111_11_0;
      else if (lu) ctl = 8'b00111_01_0;
      else ctl = 8'b11111_00_0;
    end
    exp_frozen = frozen;
    exp_ctl = ctl;
    exp_q.push_back({ctl, m_err, 16'(m_stall), 4'(m_stall_sat)});
  endtask

  // Advance one clock edge and update the model's registered view.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      m_err = 0;
      if (!m_halted) begin
        if (exp_frozen) begin
          m_frozen++;
          if (m_frozen >= TIMEOUT) begin
            m_halted = 1;
            m_err = 1;
          end
        end else begin
          m_frozen = 0;
          m_redirect = !m_redirect && branch_taken_e;
        end
      end
      if (exp_ctl[6] == 1'b0) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall_sat < 15) m_stall_sat++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    logic [W-1:0] e;
    set_idle();
    rst = 1'b1;
    settle(); e = exp_q.pop_front();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_loaduse(input logic [4:0] r);
    rd_e = r; reg_we_e = 1'b1; wb_ctr_e = 2'b01;
    rs2_d = r; rs2_need = 1'b1; rs1_need = 1'b0; rs1_d = 5'($urandom_range(0, 31));
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    logic [W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      rst = 1'b1;
      dmem_req = 1'($urandom); dmem_ack = 1'($urandom);
      branch_taken_e = 1'($urandom); set_loaduse(5'($urandom_range(1, 31)));
      settle(); e = exp_q.pop_front(); checks++;
      if (obs !== e || obs[28:21] !== 8'h00) begin
        errors++; $display("FAIL reset_hold cyc=%0d obs=%h exp=%h", i, obs, e);
      end
      tick();
    end
    rst = 1'b0;
    set_idle(); dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rst = 1'b1;
      settle(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin
        errors++; $display("FAIL reset_midwait cyc=%0d obs=%h exp=%h", i, obs, e);
      end
      tick();
    end
    rst = 1'b0; set_idle();
    settle(); e = exp_q.pop_front(); checks++;
    if (obs !== e || obs[28:21] !== 8'b11111_00_0 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_exit obs=%h exp=%h", obs, e);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [W-1:0] e;
    do_reset();
    set_loaduse(5'd5);
    settle(); e = exp_q.pop_front(); checks++;
    if (obs !== e || {en_f, en_d, flush_e} !== 3'b001) begin
      errors++; $display("FAIL load_use obs=%h exp=%h", obs, e);
    end
    tick();
    rd_e = 5'd0;
    settle(); e = exp_q.pop_front(); checks++;
    if (obs !== e || stall_cnt !== 16'd1 || obs[28:21] !== 8'b11111_00_0) begin
      errors++; $display("FAIL load_use_after obs=%h exp=%h", obs, e);
    end
    tick();
  endtask

  task automatic test_no_stall();
    logic [W-1:0] e;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_loaduse(5'd5);
      if (i == 0) begin rd_e = 5'd0; rs2_d = 5'd0; end
      else rs2_need = 1'b0;
      settle(); e = exp_q.pop_front(); checks++;
      if (obs !== e || obs[28:21] !== 8'b11111_00_0 || stall_cnt !== 16'd0) begin
        errors++; $display("FAIL no_stall case=%0d obs=%h exp=%h", i, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [W-1:0] e;
    logic [7:0] want[3];
    want[0] = 8'b11111_11_0; want[1] = 8'b11111_10_0; want[2] = 8'b11111_00_0;
    do_reset();
    set_loaduse(5'd7); branch_taken_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) set_idle();   // branch/loaduse still held during the bubble
      settle(); e = exp_q.pop_front(); checks++;
      if (obs !== e || obs[28:21] !== want[i]) begin
        errors++; $display("FAIL branch step=%0d obs=%h exp=%h", i, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_mem_ack();
    logic [W-1:0] e;
    do_reset();
    dmem_req = 1'b1; branch_taken_e = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dmem_ack = (i == 3);
      if (i == 4) set_idle();
      settle(); e = exp_q.pop_front(); checks++;
      if (obs !== e || (i < 3 && obs[28:21] !== 8'h00) ||
          (i == 3 && (obs[28:21] !== 8'b11111_11_0 || stall_cnt !== 16'd3))) begin
        errors++; $display("FAIL mem_ack step=%0d obs=%h exp=%h", i, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] e;
    do_reset();
    dmem_req = 1'b1; dmem_ack = 1'b0;
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      if (i >= TIMEOUT) begin dmem_req = 1'($urandom); dmem_ack = 1'($urandom); end
      settle(); e = exp_q.pop_front(); checks++;
      if (obs !== e || obs[27] !== 1'b0 || halted !== (i >= TIMEOUT) ||
          mem_err !== (i == TIMEOUT)) begin
        errors++; $display("FAIL timeout cyc=%0d obs=%h exp=%h", i, obs, e);
      end
      tick();
    end
    rst = 1'b1;
    settle(); e = exp_q.pop_front(); checks++;
    if (obs !== e || halted !== 1'b0) begin
      errors++; $display("FAIL halt_rst obs=%h exp=%h", obs, e);
    end
    tick();
    rst = 1'b0; set_idle();
    settle(); e = exp_q.pop_front(); checks++;
    if (obs !== e || stall_cnt !== 16'd0 || obs[28:21] !== 8'b11111_00_0) begin
      errors++; $display("FAIL halt_exit obs=%h exp=%h", obs, e);
    end
    tick();
  endtask

  task automatic test_saturation();
    logic [W-1:0] e;
    do_reset();
    set_loaduse(5'd9);
    for (int i = 0; i < 20; i++) begin
      settle(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin
        errors++; $display("FAIL sat cyc=%0d obs=%h exp=%h", i, obs, e);
      end
      tick();
    end
    set_idle();
    settle(); e = exp_q.pop_front(); checks++;
    if (obs !== e || stall_cnt_sat !== 4'hF || stall_cnt !== 16'd20) begin
      errors++; $display("FAIL sat_hold sat=%h cnt=%0d exp=%h", stall_cnt_sat, stall_cnt, e);
    end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    int ack_pct;
    do_reset();
    ack_pct = 50;
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) ack_pct = $urandom_range(0, 3) * 25;
      rst = ($urandom_range(0, 149) == 0);
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rd_e = 5'($urandom_range(0, 3));
      rs1_need = 1'($urandom); rs2_need = 1'($urandom);
      reg_we_e = 1'($urandom); wb_ctr_e = 2'($urandom);
      branch_taken_e = ($urandom_range(0, 5) == 0);
      dmem_req = ($urandom_range(0, 3) == 0);
      dmem_ack = ($urandom_range(0, 99) < ack_pct);
      settle(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin
        errors++; $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs, e);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    checks = 0; errors = 0;
    set_idle(); rst = 1'b1;
    model_clear();
    @(negedge clk);
    tick();
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_mem_ack();
    test_timeout();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
